// File: rtl/clock_enable_scheduler_pkg.sv
// Shared definitions for the clock-enable scheduler: FSM encoding and board defaults.
package clk_sched_pkg;

  localparam int CNT_W_DEF       = 26;
  localparam int REP_W_DEF       = 8;
  // 0.5 s tick on a 50 MHz board
  localparam int DEFAULT_DIV_DEF = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/clock_enable_scheduler_if.sv
// Config handshake bundle: divide ratio, run mode and one-shot repeat count.
interface clock_enable_scheduler_if #(
  parameter int CNT_W = clk_sched_pkg::CNT_W_DEF,
  parameter int REP_W = clk_sched_pkg::REP_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_oneshot;
  logic [REP_W-1:0] cfg_reps;

  modport master (
    output cfg_valid, cfg_div, cfg_oneshot, cfg_reps,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_oneshot, cfg_reps,
    output cfg_ready
  );
endinterface

// File: rtl/clock_enable_scheduler_div_counter.sv
// Divide counter: counts 0..div-1 while enabled and flags the terminal count.
module div_counter
  import clk_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // clear dominates so an abort on the terminal cycle never reports a tick
  always_comb begin
    tc_o    = en_i && !clr_i && (count_q == (div_i - CNT_W'(1)));
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = tc_o ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Restartable clock-enable scheduler: config handshake, run FSM, tick and divided clock.
module clock_enable_scheduler
  import clk_sched_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               REP_W       = REP_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  clock_enable_scheduler_if.slave  cfg,
  input  logic                     start,
  input  logic                     stop,
  output logic                     tick,
  output logic                     out_clk,
  output logic                     busy,
  output logic                     done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             oneshot_q, oneshot_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             tick_q, tick_d;
  logic             out_clk_q, out_clk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             cfg_fire;
  logic [CNT_W-1:0] cfg_div_eff;
  logic             cnt_clr, cnt_en, cnt_tc;

  assign cfg_fire    = cfg.cfg_valid && ready_q;
  assign cfg_div_eff = (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;

  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q != ST_RUN) || stop;

  div_counter #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .div_i (div_q),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    reps_d    = reps_q;
    rep_cnt_d = rep_cnt_q;
    tick_d    = 1'b0;
    out_clk_d = out_clk_q;
    done_d    = 1'b0;

    if (cfg_fire) begin
      div_d     = cfg_div_eff;
      oneshot_d = cfg.cfg_oneshot;
      reps_d    = cfg.cfg_reps;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          // a config landing on the start edge governs this run
          rep_cnt_d = cfg_fire ? cfg.cfg_reps : reps_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          out_clk_d = 1'b0;
        end else if (cnt_tc) begin
          tick_d    = 1'b1;
          out_clk_d = ~out_clk_q;
          if (oneshot_q) begin
            rep_cnt_d = rep_cnt_q - REP_W'(1);
            if (rep_cnt_q == REP_W'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_RUN);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= DEFAULT_DIV;
      oneshot_q <= 1'b0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      tick_q    <= 1'b0;
      out_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      tick_q    <= tick_d;
      out_clk_q <= out_clk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign tick          = tick_q;
  assign out_clk       = out_clk_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Bench for clock_enable_scheduler: directed scenarios plus random traffic against a cycle-level model.
module tb_clock_enable_scheduler;
  localparam int CNT_W = 26;
  localparam int REP_W = 8;
  localparam int DDIV  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic tick, out_clk, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  clock_enable_scheduler_if #(.CNT_W(CNT_W), .REP_W(REP_W)) cif ();

  clock_enable_scheduler #(
    .CNT_W(CNT_W), .REP_W(REP_W), .DEFAULT_DIV(CNT_W'(DDIV))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg     (cif.slave),
    .start   (start),
    .stop    (stop),
    .tick    (tick),
    .out_clk (out_clk),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is described by elapsed edges since start and ticks delivered so far.
  int m_phase, m_div, m_os, m_reps, m_n, m_ticks, m_target;
  bit e_tick, e_out, e_busy, e_done, e_ready;

  always @(posedge clk) begin : model
    bit fire;
    fire = cif.cfg_valid && e_ready;
    if (reset) begin
      m_phase = 0; m_div = DDIV; m_os = 0; m_reps = 0;
      e_tick = 0; e_out = 0; e_busy = 0; e_done = 0; e_ready = 1;
    end else begin
      e_tick = 0;
      e_done = 0;
      case (m_phase)
        0: begin
          if (fire) begin
            m_div  = (cif.cfg_div == 0) ? 1 : int'(cif.cfg_div);
            m_os   = int'(cif.cfg_oneshot);
            m_reps = int'(cif.cfg_reps);
          end
          if (start) begin
            m_phase  = 1;
            m_n      = 0;
            m_ticks  = 0;
            m_target = (m_reps == 0) ? (1 << REP_W) : m_reps;
          end
        end
        1: begin
          m_n++;
          if (stop) begin
            m_phase = 0;
            e_out   = 0;
          end else if (m_n % m_div == 0) begin
            e_tick = 1;
            e_out  = !e_out;
            m_ticks++;
            if (m_os != 0 && m_ticks == m_target) begin
              m_phase = 2;
              e_done  = 1;
            end
          end
        end
        default: m_phase = 0;
      endcase
      e_busy  = (m_phase == 1);
      e_ready = (m_phase == 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tick", tick, e_tick);
      chk("m_out_clk", out_clk, e_out);
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      chk("m_cfg_ready", cif.cfg_ready, e_ready);
    end
  end

  task automatic tk();
    @(negedge clk);
  endtask

  task automatic offer(input int dv, input bit os, input int rp, input bit st);
    cif.cfg_valid   = 1'b1;
    cif.cfg_div     = CNT_W'(dv);
    cif.cfg_oneshot = os;
    cif.cfg_reps    = REP_W'(rp);
    start           = st;
    tk();
    cif.cfg_valid   = 1'b0;
    start           = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tk();
    stop = 1'b0;
  endtask

  initial begin
    int ticks;
    bit dn, flag;
    cif.cfg_valid = 1'b0; cif.cfg_div = '0; cif.cfg_oneshot = 1'b0; cif.cfg_reps = '0;
    reset = 1'b1;
    repeat (2) tk();
    cmp_en = 1'b1;
    reset = 1'b0;
    repeat (10) tk();
    chk("rst_tick", tick, 0);
    chk("rst_out_clk", out_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cif.cfg_ready, 1);

    // default ratio: first tick 4 edges after start
    start = 1'b1; tk(); start = 1'b0;
    chk("def_busy", busy, 1);
    flag = 0;
    repeat (3) begin tk(); flag |= tick; end
    chk("def_early_tick", flag, 0);
    tk();
    chk("def_tick", tick, 1);
    chk("def_out_clk", out_clk, 1);
    do_stop();
    chk("def_stop_busy", busy, 0);
    chk("def_stop_out", out_clk, 0);

    // continuous div 3
    offer(3, 0, 0, 0);
    start = 1'b1; tk(); start = 1'b0;
    ticks = 0;
    repeat (9) begin tk(); ticks += int'(tick); end
    chk("c3_ticks", ticks, 3);
    chk("c3_tick_last", tick, 1);
    chk("c3_out_clk", out_clk, 1);
    do_stop();

    // one-shot div 2 x3, config on the start edge
    offer(2, 1, 3, 1);
    ticks = 0; dn = 0;
    for (int i = 0; i < 50 && !dn; i++) begin
      tk(); ticks += int'(tick); if (done) dn = 1;
    end
    chk("os3_done", dn, 1);
    chk("os3_ticks", ticks, 3);
    chk("os3_ready_in_done", cif.cfg_ready, 0);
    tk();
    chk("os3_ready_after", cif.cfg_ready, 1);
    chk("os3_busy_after", busy, 0);

    // one-shot reps 0 means 256
    offer(2, 1, 0, 1);
    ticks = 0; dn = 0;
    for (int i = 0; i < 1000 && !dn; i++) begin
      tk(); ticks += int'(tick); if (done) dn = 1;
    end
    chk("os0_done", dn, 1);
    chk("os0_ticks", ticks, 256);
    tk();

    // continuous div 5, config refused while running, stop mid-period
    offer(5, 0, 0, 1);
    repeat (5) tk();
    chk("c5_tick1", tick, 1);
    cif.cfg_valid = 1'b1; cif.cfg_div = CNT_W'(9);
    tk();
    chk("c5_ready_run", cif.cfg_ready, 0);
    tk();
    cif.cfg_valid = 1'b0;
    do_stop();
    chk("c5_stop_busy", busy, 0);
    chk("c5_stop_out", out_clk, 0);
    ticks = 0;
    repeat (10) begin tk(); ticks += int'(tick); end
    chk("c5_quiet", ticks, 0);
    start = 1'b1; tk(); start = 1'b0;
    flag = 0;
    repeat (4) begin tk(); flag |= tick; end
    chk("c5_kept_early", flag, 0);
    tk();
    chk("c5_kept_tick", tick, 1);
    do_stop();

    // div 0 stored as 1: tick every cycle
    offer(0, 0, 0, 1);
    chk("d0_first", tick, 0);
    repeat (5) begin tk(); chk("d0_tick", tick, 1); end
    do_stop();

    // stop on the final one-shot tick wins
    offer(2, 1, 2, 1);
    repeat (3) tk();
    do_stop();
    chk("sf_tick", tick, 0);
    chk("sf_done", done, 0);
    chk("sf_busy", busy, 0);
    tk();
    chk("sf_done_late", done, 0);

    // reset mid-run restores default ratio
    offer(7, 0, 0, 1);
    repeat (4) tk();
    reset = 1'b1; tk(); reset = 1'b0;
    chk("rr_tick", tick, 0);
    chk("rr_out", out_clk, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ready", cif.cfg_ready, 1);
    start = 1'b1; tk(); start = 1'b0;
    flag = 0;
    repeat (3) begin tk(); flag |= tick; end
    chk("rr_early", flag, 0);
    tk();
    chk("rr_tick_def", tick, 1);
    do_stop();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 499) == 0);
      start           = ($urandom_range(0, 3) == 0);
      stop            = ($urandom_range(0, 11) == 0);
      cif.cfg_valid   = ($urandom_range(0, 2) == 0);
      cif.cfg_div     = CNT_W'($urandom_range(0, 6));
      cif.cfg_oneshot = $urandom_range(0, 1) == 1;
      cif.cfg_reps    = REP_W'($urandom_range(0, 4));
      tk();
    end
    reset = 1'b0; start = 1'b0; cif.cfg_valid = 1'b0;
    do_stop();
    tk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
